serial_paralelo_lane: RTL and testbench

SERIAL_PARALELO_LANE -- requirements
Module: serial_paralelo_lane

---
 rtl/serial_paralelo_lane.sv | 139 +++++++++++++
 tb/tb_serial_paralelo_lane.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_lane.sv
`default_nettype none
// ============================================================================
// Module   : serial_paralelo_lane
// Purpose  : Serial-to-parallel receive lane. Finds COM-word alignment on a
//            1-bit serial stream at any bit offset, confirms it over
//            SYNC_COUNT consecutive aligned COM words, then emits each 32-bit
//            non-COM word on lane_out at its word boundary.
// Ports    : clk_32f   - bit clock, one serial bit per rising edge
//            reset     - asynchronous active-high reset
//            data_in   - serial bit, MSB of each word first
//            lane_out  - last received data (non-COM) word, registered
//            valid_out - lane_out holds a data word (0 while idling on COM)
//            active    - lane aligned and synchronised (sticky until reset)
// Revision : 1.0 - initial release
// ============================================================================
module serial_paralelo_lane #(
  parameter logic [31:0] COM_WORD   = 32'hBCBCBCBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [31:0] lane_out,
  output logic        valid_out,
  output logic        active
);

  // Counter wide enough to hold SYNC_COUNT itself.
  localparam int unsigned c_CNT_W = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);
  localparam logic [c_CNT_W-1:0] c_SYNC = c_CNT_W'(SYNC_COUNT);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
  localparam logic [4:0]         c_LAST_BIT = 5'd31;

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_ALIGNING = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_sr;
  logic [4:0]         r_bit_cnt;
  logic [c_CNT_W-1:0] r_com_cnt;
  logic [31:0]        r_lane;
  logic               r_valid;
  logic               r_active;

  state_t             w_state_nxt;
  logic [4:0]         w_bit_cnt_nxt;
  logic [c_CNT_W-1:0] w_com_cnt_nxt;
  logic [31:0]        w_lane_nxt;
  logic               w_valid_nxt;
  logic [31:0]        w_word;
  logic               w_is_com;
  logic               w_boundary;

  // Candidate word includes the bit being sampled on this edge.
  assign w_word     = {r_sr[30:0], data_in};
  assign w_is_com   = (w_word == COM_WORD);
  assign w_boundary = (r_bit_cnt == c_LAST_BIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 5'd1;   // natural 31 -> 0 wrap
    w_com_cnt_nxt = r_com_cnt;
    w_lane_nxt    = r_lane;
    w_valid_nxt   = r_valid;

    case (r_state)
      ST_SEARCH: begin
        // Sliding search: bit_cnt is meaningless here and held at 0 so the
        // first edge after a match starts bit 0 of the next word.
        w_bit_cnt_nxt = 5'd0;
        if (w_is_com) begin
          w_com_cnt_nxt = c_ONE;
          w_state_nxt   = (c_ONE == c_SYNC) ? ST_ACTIVE : ST_ALIGNING;
        end
      end

      ST_ALIGNING: begin
        if (w_boundary) begin
          if (w_is_com) begin
            w_com_cnt_nxt = r_com_cnt + c_ONE;
            if ((r_com_cnt + c_ONE) == c_SYNC) begin
              w_state_nxt = ST_ACTIVE;
            end
          end else begin
            // The breaking word is not re-examined for a sliding match.
            w_com_cnt_nxt = '0;
            w_state_nxt   = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        if (w_boundary) begin
          if (w_is_com) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_lane_nxt  = w_word;
            w_valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt   = ST_SEARCH;
        w_com_cnt_nxt = '0;
        w_bit_cnt_nxt = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state   <= ST_SEARCH;
      r_sr      <= 32'h0;
      r_bit_cnt <= 5'd0;
      r_com_cnt <= '0;
      r_lane    <= 32'h0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_word;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_com_cnt <= w_com_cnt_nxt;
      r_lane    <= w_lane_nxt;
      r_valid   <= w_valid_nxt;
      r_active  <= (w_state_nxt == ST_ACTIVE);
    end
  end

  assign lane_out  = r_lane;
  assign valid_out = r_valid;
  assign active    = r_active;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_lane.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_paralelo_lane
// Purpose  : Self-checking bench for serial_paralelo_lane. Each segment is a
//            bit stream; a reference model derives the expected outputs after
//            every bit, a driver pushes them to a queue, and a monitor pops
//            and compares once per sampled bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_lane;

  localparam logic [31:0] COM  = 32'hBCBCBCBC;
  localparam int          SYNC = 4;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b1;
  logic        data_in = 1'b0;
  logic [31:0] lane_out;
  logic        valid_out;
  logic        active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic        act;
    logic        val;
    logic [31:0] lane;
  } exp_t;

  exp_t exp_q[$];
  logic seg_bits[$];

  serial_paralelo_lane #(
    .COM_WORD  (COM),
    .SYNC_COUNT(SYNC)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .lane_out (lane_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // 32-bit window ending at bit index i; bits before the segment are the
  // zeros left in the shift register by reset.
  function automatic logic [31:0] word_at(input int i);
    logic [31:0] w;
    w = '0;
    for (int j = i - 31; j <= i; j++)
      w = {w[30:0], (j >= 0 && j < seg_bits.size()) ? seg_bits[j] : 1'b0};
    return w;
  endfunction

  task automatic add_word(input logic [31:0] w);
    for (int k = 31; k >= 0; k--) seg_bits.push_back(w[k]);
  endtask

  task automatic add_rand_bits(input int n);
    for (int k = 0; k < n; k++) seg_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] w;
    w = $urandom();
    while (w == COM) w = $urandom();
    return w;
  endfunction

  // Reference model and driver. Alignment: find the first sliding COM
  // match, then require SYNC-1 further COM words every 32 bits; a break
  // resumes the sliding search one bit after the breaking word.
  task automatic run_segment(input int abort_at, input bit do_reset);
    exp_t        plan[$];
    exp_t        e;
    int          n;
    int          act_idx;
    int          from;
    int          hit;
    bit          ok;
    logic        val;
    logic [31:0] lane;
    logic [31:0] w;

    n = seg_bits.size();
    act_idx = -1;
    from = 0;
    while (act_idx < 0 && from < n) begin
      hit = -1;
      for (int i = from; i < n; i++) begin
        if (word_at(i) == COM) begin
          hit = i;
          break;
        end
      end
      if (hit < 0) break;
      ok = 1'b1;
      for (int k = 1; k < SYNC; k++) begin
        if (hit + 32 * k >= n) begin
          ok = 1'b0; from = n; break;
        end
        if (word_at(hit + 32 * k) != COM) begin
          ok = 1'b0; from = hit + 32 * k + 1; break;
        end
      end
      if (ok) act_idx = hit + 32 * (SYNC - 1);
    end

    val = 1'b0;
    lane = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (act_idx >= 0 && i > act_idx && ((i - act_idx) % 32) == 0) begin
        w = word_at(i);
        if (w != COM) begin
          val = 1'b1; lane = w;
        end else begin
          val = 1'b0;
        end
      end
      e.idx  = i;
      e.act  = (act_idx >= 0 && i >= act_idx);
      e.val  = val;
      e.lane = lane;
      plan.push_back(e);
    end

    if (do_reset) begin
      @(negedge clk_32f);
      reset = 1'b1;
      data_in = 1'b0;
      repeat (2) @(negedge clk_32f);
      check("rst_lane", lane_out, 32'h0);
      check("rst_valid", {31'h0, valid_out}, 32'h0);
      check("rst_active", {31'h0, active}, 32'h0);
      reset = 1'b0;
    end else begin
      @(negedge clk_32f);
    end

    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk_32f);
      data_in = seg_bits[i];
      exp_q.push_back(plan[i]);
      if (i == abort_at) begin
        @(posedge clk_32f);
        #2;
        reset = 1'b1;
        data_in = 1'b0;
        #1;
        check("async_rst_lane", lane_out, 32'h0);
        check("async_rst_valid", {31'h0, valid_out}, 32'h0);
        check("async_rst_active", {31'h0, active}, 32'h0);
        exp_q.delete();
        #5;
        reset = 1'b0;
        return;
      end
    end
    @(posedge clk_32f);
    #2;
  endtask

  // Monitor: one expectation per bit sampled out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_32f);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (active !== e.act || valid_out !== e.val || lane_out !== e.lane) begin
          errors++;
          $display("FAIL bit%0d got act=%b val=%b lane=%h want act=%b val=%b lane=%h",
                   e.idx, active, valid_out, lane_out, e.act, e.val, e.lane);
        end
      end
    end
  end

  initial begin
    int ncom;

    // Aligned start, single data word.
    seg_bits.delete();
    repeat (4) add_word(COM);
    add_word(32'hA1B2C3D4);
    run_segment(-1, 1'b1);
    check("s1_lane", lane_out, 32'hA1B2C3D4);
    check("s1_valid", {31'h0, valid_out}, 32'h1);

    // Five-bit offset before the COM words.
    seg_bits.delete();
    add_rand_bits(5);
    repeat (4) add_word(COM);
    add_word(32'h12345678);
    run_segment(-1, 1'b1);
    check("s2_lane", lane_out, 32'h12345678);
    check("s2_active", {31'h0, active}, 32'h1);

    // Broken alignment, then recovery.
    seg_bits.delete();
    repeat (2) add_word(COM);
    add_word(32'h00FF00FF);
    repeat (4) add_word(COM);
    add_word(32'hDEADBEEF);
    run_segment(-1, 1'b1);
    check("s3_lane", lane_out, 32'hDEADBEEF);

    // Data, idle, data in ACTIVE.
    seg_bits.delete();
    repeat (4) add_word(COM);
    add_word(32'h11111111);
    add_word(COM);
    add_word(32'h22222222);
    run_segment(-1, 1'b1);
    check("s4_lane", lane_out, 32'h22222222);

    // Asynchronous reset mid data word, then only three COM words.
    seg_bits.delete();
    repeat (4) add_word(COM);
    add_word(32'h33333333);
    add_word(32'h44444444);
    run_segment(5 * 32 + 15, 1'b1);
    seg_bits.delete();
    repeat (3) add_word(COM);
    add_word(32'h55555555);
    add_word(32'h66666666);
    run_segment(-1, 1'b0);
    check("s5_active", {31'h0, active}, 32'h0);
    check("s5_valid", {31'h0, valid_out}, 32'h0);

    // Randomised segments.
    for (int s = 0; s < 20; s++) begin
      seg_bits.delete();
      add_rand_bits($urandom_range(0, 40));
      ncom = $urandom_range(1, 5);
      repeat (ncom) add_word(COM);
      if ($urandom_range(0, 2) == 0) begin
        add_word(rand_data());
        repeat (4) add_word(COM);
      end
      for (int k = 0; k < 6; k++)
        add_word(($urandom_range(0, 3) == 0) ? COM : rand_data());
      run_segment(-1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
